aes_decrypt: RTL
================

Name: aes_decrypt

Overview:
Iterative AES-128 inverse cipher; the decrypt counterpart of the existing `aes` encryption core, with the same port style and byte mapping. It is mapped into the USB register space beside `aes`: ciphertext, key and trigger come from `memory_input`; plaintext, done and busy go to `memory_output`. Processing is one round per clock. The block first runs the key schedule forward to round key 10, then unwinds it in place while applying the inverse rounds.

Parameters:
None. AES-128 is fixed.

Ports:
clk  in  1  main clock (main_clk)
reset  in  1  asynchronous, active-high reset
key  in  128  cipher key; block byte i at bits [8i+7:8i] (byte 0 = first FIPS-197 byte)
ciphertext  in  128  input block, same byte mapping
trigger  in  1  level from the register bit; its rising edge starts one decryption
plaintext  out  128  result, same byte mapping
done  out  1  high once a decryption finishes, held until the next start
busy  out  1  high while a decryption is in progress

Behaviour:
- Reset (async, active-high): state=IDLE; plaintext, done, busy, trig_q, counters and internal key/state registers all 0.
- trig_q registers trigger every cycle. Start = trigger & ~trig_q & (state==IDLE || state==DONE).
- Start edge (E0):
  - latch key into kreg and ciphertext into ct_q;
  - rcon←0x01, rnd←0, done←0, busy←1, state←KEYEXP.
- KEYEXP, edges E1..E10:
  - kreg←forward_expand(kreg, rcon); rcon←xtime(rcon).
  - At E10: kreg holds rk10; sreg←ct_q ^ rk10; rcon←0x36; state←ROUND.
- ROUND, edges E11..E20:
  - nk = inverse_expand(kreg, rcon), where w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{rcon,0,0,0}.
  - kreg←nk.
  - rcon←(rcon[0] ? (rcon>>1)^0x8D : rcon>>1), giving the sequence 36,1B,80,40,…,01.
  - sreg←InvMixColumns(InvSubBytes(InvShiftRows(sreg)) ^ nk) for E11..E19.
  - At E20, InvMixColumns is omitted and the result goes to plaintext, not sreg. Also done←1, busy←0, state←DONE.
- Latency: done rises on the 20th edge after the start edge, fixed and data-independent.
- DONE behaves as IDLE for start detection. plaintext and done hold until the next start.
- At a new start, done drops on E0; plaintext keeps its old value until E20.
- Trigger held high: only one run. trigger must return low and rise again to restart.
- Rising edge while busy: ignored, no queuing. trig_q still tracks, so a level that stays high does not fire after completion.
- key/ciphertext changes after E0: no effect on the current run.
- Reset mid-operation: immediate abort to the reset values; no partial plaintext is visible.
- Simultaneous reset and start: reset wins.
- All S-box lookups are combinational. There is no multicycle path.

Decomposition:
- Shared package aes_pkg, used by both aes and aes_decrypt:
  - functions sbox, inv_sbox, xtime, gmul (by 9/11/13/14);
  - constant RCON_FIRST=0x01, RCON_LAST=0x36;
  - enum {IDLE, KEYEXP, ROUND, DONE} as a 2-bit state type.
- Sub-module aes_inv_round: combinational, inputs state, rk and last_flag; output is the next state (InvShiftRows→InvSubBytes→AddRoundKey→optional InvMixColumns).
- The key schedule stays in aes_decrypt.

Test Plan:
- FIPS-197 C.1:
  - stimulus: key bytes 000102…0f, ciphertext bytes 69c4e0d86a7b0430d8cdb78070b4c55a, trigger 0→1;
  - response: plaintext bytes 00112233445566778899aabbccddeeff; done rises exactly 20 cycles after the start edge; busy high for E0..E19.
- FIPS-197 Appendix B:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32;
  - response: plaintext 3243f6a8885a308d313198a2e0370734.
- All-zero key with ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e → plaintext all zero.
- Trigger held high 50 cycles → exactly one run; a second 0→1 pulse at cycle 10 of a run → ignored, done still at +20.
- Change key/ciphertext at E5 → plaintext matches the values latched at E0.
- Assert reset at E12 → plaintext=0, done=0, busy=0 immediately. A fresh trigger edge afterwards still gives the correct result in 20 cycles; verify back-to-back runs with the aes core round-trip on random vectors.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and GF(2^8) helpers for the aes and aes_decrypt cores.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_state_t;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, which conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_sub;
    logic [127:0] w_add;
    logic [127:0] w_mix;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = a;
        return {gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09)};
    endfunction

    // Byte r+4c of the state is row r, column c; row r rotates right by r.
    always_comb begin
        w_sub = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sub[8*(r+4*c) +: 8] = inv_sbox(i_state[8*(r+4*((c-r)&3)) +: 8]);
            end
        end
        w_add = w_sub ^ i_rk;
        w_mix = '0;
        for (int c = 0; c < 4; c++) begin
            w_mix[32*c +: 32] = inv_mix_col(w_add[32*c +: 32]);
        end
        o_state = i_last ? w_add : w_mix;
    end

endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - iterative AES-128 inverse cipher, one round per clock; expands the key
// forward to round key 10, then unwinds it in place while running the inverse rounds.
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    input  logic         trigger,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy
);

    aes_state_t   r_state;
    aes_state_t   w_next_state;
    logic         r_trig_q;
    logic [127:0] r_kreg;
    logic [127:0] r_ct_q;
    logic [127:0] r_sreg;
    logic [127:0] r_plain;
    logic [7:0]   r_rcon;
    logic [3:0]   r_rnd;
    logic         r_done;
    logic         r_busy;
    logic         w_start;
    logic         w_last;
    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;
    logic [127:0] w_round_out;

    // SubWord(RotWord(w)) with rcon folded into the first byte; byte 0 of a word sits in bits [7:0].
    function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[7:0]), sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]) ^ rc};
    endfunction

    function automatic logic [127:0] forward_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[31:0] ^ sub_rot(k[127:96], rc);
        w1 = k[63:32] ^ w0;
        w2 = k[95:64] ^ w1;
        w3 = k[127:96] ^ w2;
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] inverse_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[127:96] ^ k[95:64];
        w2 = k[95:64] ^ k[63:32];
        w1 = k[63:32] ^ k[31:0];
        w0 = k[31:0] ^ sub_rot(w3, rc);
        return {w3, w2, w1, w0};
    endfunction

    assign w_start   = trigger & ~r_trig_q & ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_rnd == 4'd9);
    assign w_fwd_key = forward_expand(r_kreg, r_rcon);
    assign w_inv_key = inverse_expand(r_kreg, r_rcon);

    aes_inv_round u_inv_round (
        .i_state (r_sreg),
        .i_rk    (w_inv_key),
        .i_last  (w_last),
        .o_state (w_round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_next_state = KEYEXP;
            KEYEXP:     if (w_last)  w_next_state = ROUND;
            ROUND:      if (w_last)  w_next_state = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_q <= 1'b0;
            r_kreg   <= '0;
            r_ct_q   <= '0;
            r_sreg   <= '0;
            r_plain  <= '0;
            r_rcon   <= 8'h00;
            r_rnd    <= 4'd0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_trig_q <= trigger;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_kreg <= key;
                        r_ct_q <= ciphertext;
                        r_rcon <= RCON_FIRST;
                        r_rnd  <= 4'd0;
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                KEYEXP: begin
                    r_kreg <= w_fwd_key;
                    r_rnd  <= r_rnd + 4'd1;
                    r_rcon <= xtime(r_rcon);
                    if (w_last) begin
                        r_sreg <= r_ct_q ^ w_fwd_key;
                        r_rcon <= RCON_LAST;
                        r_rnd  <= 4'd0;
                    end
                end
                ROUND: begin
                    r_kreg <= w_inv_key;
                    r_rnd  <= r_rnd + 4'd1;
                    r_rcon <= r_rcon[0] ? ((r_rcon >> 1) ^ 8'h8d) : (r_rcon >> 1);
                    if (w_last) begin
                        r_plain <= w_round_out;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sreg <= w_round_out;
                    end
                end
            endcase
        end
    end

    assign plaintext = r_plain;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule
